stream_mux_rr: RTL and testbench

- Parametrised N-channel, registered stream multiplexer; successor to the 4:1 gate-level mux.
- Selects one of NUM_CH valid/ready input streams and forwards it through one output register stage.
- Three arbitration modes: round-robin, fixed priority, and manual select, which is the legacy mux behaviour.
- Grants are held for a whole packet, delimited by in_last, so packets are never interleaved on the output bus.

---
 rtl/stream_mux_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 62 ++++++
 rtl/stream_mux_rr.sv | 107 ++++++++++
 tb/tb_stream_mux_rr.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the registered round-robin stream multiplexer.
// Encodings of the mode input. Code 3 is reserved and arbitrates like MODE_RR.
package stream_mux_pkg;
    localparam logic [1:0] MODE_RR   = 2'd0;
    localparam logic [1:0] MODE_PRIO = 2'd1;
    localparam logic [1:0] MODE_MAN  = 2'd2;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter: locked channel, round-robin, fixed priority or manual select.
// A grant is only ever issued to a channel whose request is asserted.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic              lock,
    input  logic [SEL_W-1:0]  lock_ch,
    output logic              grant_vld,
    output logic [SEL_W-1:0]  grant_idx
);

    always_comb begin
        int cand;
        logic found;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        found     = 1'b0;
        if (lock) begin
            grant_idx = lock_ch;
            grant_vld = req[lock_ch];
        end else begin
            case (mode)
                MODE_MAN: begin
                    if ((int'(sel) < NUM_CH) && req[sel]) begin
                        grant_vld = 1'b1;
                        grant_idx = sel;
                    end
                end
                MODE_PRIO: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (!found && req[SEL_W'(i)]) begin
                            found     = 1'b1;
                            grant_idx = SEL_W'(i);
                        end
                    end
                    grant_vld = found;
                end
                default: begin
                    // Search starts one past the last packet's channel, wrapping modulo NUM_CH.
                    for (int i = 1; i <= NUM_CH; i++) begin
                        cand = int'(ptr) + i;
                        if (cand >= NUM_CH) cand = cand - NUM_CH;
                        if (!found && req[SEL_W'(cand)]) begin
                            found     = 1'b1;
                            grant_idx = SEL_W'(cand);
                        end
                    end
                    grant_vld = found;
                end
            endcase
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with one output register stage and packet-atomic grants.
// Owns the round-robin pointer, the packet lock and the valid/ready handshake.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  ptr_q,       ptr_d;
    logic              lock_q,      lock_d;
    logic [SEL_W-1:0]  lock_ch_q,   lock_ch_d;

    logic              grant_vld;
    logic [SEL_W-1:0]  grant_idx;
    logic              load;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .mode      (mode),
        .sel       (sel),
        .lock      (lock_q),
        .lock_ch   (lock_ch_q),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    always_comb begin
        load        = !out_valid_q || out_ready;
        xfer        = grant_vld && load && !rst;
        sel_data    = in_data[int'(grant_idx)*DATA_W +: DATA_W];
        in_ready    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        if (xfer) in_ready[grant_idx] = 1'b1;
        if (load) out_valid_d = xfer;
        if (xfer) begin
            out_data_d = sel_data;
            out_last_d = in_last[grant_idx];
            out_ch_d   = grant_idx;
            // The pointer only advances at packet end so a packet never loses its slot.
            if (in_last[grant_idx]) begin
                lock_d = 1'b0;
                ptr_d  = grant_idx;
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= SEL_W'(NUM_CH - 1);
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr with hand-computed expectations.
module tb_stream_mux_rr;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [1:0]               mode;
   logic [SEL_W-1:0]         sel;
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH-1:0]        in_last;
   logic [NUM_CH-1:0]        in_ready;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_last;
   logic [SEL_W-1:0]         out_ch;
   logic                     out_ready;

   int total = 0;
   int bad   = 0;

   stream_mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Drives every control input at once and lets the combinational paths settle.
   task automatic applyStimulus(input logic r, input logic [1:0] m, input logic [1:0] s,
                                input logic [3:0] v, input logic [3:0] l, input logic ordy);
      rst       = r;
      mode      = m;
      sel       = s;
      in_valid  = v;
      in_last   = l;
      out_ready = ordy;
      #1;
   endtask

   // One clock edge, then sample away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      in_data = {8'h13, 8'h12, 8'h11, 8'h10};

      // Reset with every channel requesting: nothing may be accepted.
      applyStimulus(1'b1, 2'd0, 2'd0, 4'b1111, 4'b1111, 1'b1);
      tick();
      tick();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'h0);
      checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'h0);

      // Round-robin with single-beat packets: 0,1,2,3,0.
      applyStimulus(1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 1'b1);
      checkOutput("rr_first_ready", 32'(in_ready), 32'b0001);
      checkOutput("rr_valid_before", 32'(out_valid), 32'd0);
      tick();
      checkOutput("rr_valid_rise", 32'(out_valid), 32'd1);
      checkOutput("rr_ch0", 32'(out_ch), 32'd0);
      checkOutput("rr_data0", 32'(out_data), 32'h10);
      checkOutput("rr_ready1", 32'(in_ready), 32'b0010);
      tick();
      checkOutput("rr_ch1", 32'(out_ch), 32'd1);
      tick();
      checkOutput("rr_ch2", 32'(out_ch), 32'd2);
      tick();
      checkOutput("rr_ch3", 32'(out_ch), 32'd3);
      checkOutput("rr_data3", 32'(out_data), 32'h13);
      tick();
      checkOutput("rr_wrap_ch0", 32'(out_ch), 32'd0);

      // Three-beat packet on ch1 while ch2 waits; a mid-packet valid gap bubbles.
      applyStimulus(1'b0, 2'd0, 2'd0, 4'b0110, 4'b0100, 1'b1);
      checkOutput("pkt_ready_b1", 32'(in_ready), 32'b0010);
      tick();
      checkOutput("pkt_ch_b1", 32'(out_ch), 32'd1);
      checkOutput("pkt_last_b1", 32'(out_last), 32'd0);
      applyStimulus(1'b0, 2'd0, 2'd0, 4'b0100, 4'b0100, 1'b1);
      checkOutput("lock_gap_ready", 32'(in_ready), 32'b0000);
      tick();
      checkOutput("lock_gap_bubble", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 2'd1, 2'd0, 4'b0110, 4'b0100, 1'b1);
      checkOutput("pkt_ready_b2", 32'(in_ready), 32'b0010);
      tick();
      checkOutput("pkt_ch_b2", 32'(out_ch), 32'd1);
      checkOutput("pkt_valid_b2", 32'(out_valid), 32'd1);
      applyStimulus(1'b0, 2'd0, 2'd0, 4'b0110, 4'b0110, 1'b1);
      checkOutput("pkt_ready_b3", 32'(in_ready), 32'b0010);
      tick();
      checkOutput("pkt_ch_b3", 32'(out_ch), 32'd1);
      checkOutput("pkt_last_b3", 32'(out_last), 32'd1);
      checkOutput("pkt_next_ready", 32'(in_ready), 32'b0100);
      tick();
      checkOutput("pkt_then_ch2", 32'(out_ch), 32'd2);

      // Fixed priority: ch1 beats ch3 every cycle.
      applyStimulus(1'b0, 2'd1, 2'd0, 4'b1010, 4'b1111, 1'b1);
      checkOutput("prio_ready", 32'(in_ready), 32'b0010);
      tick();
      checkOutput("prio_ch_a", 32'(out_ch), 32'd1);
      checkOutput("prio_ready_again", 32'(in_ready), 32'b0010);
      tick();
      checkOutput("prio_ch_b", 32'(out_ch), 32'd1);

      // Manual select of ch2, then an idle selected channel.
      in_data[2*DATA_W +: DATA_W] = 8'hA5;
      applyStimulus(1'b0, 2'd2, 2'd2, 4'b0101, 4'b1111, 1'b1);
      checkOutput("man_ready", 32'(in_ready), 32'b0100);
      tick();
      checkOutput("man_data", 32'(out_data), 32'hA5);
      checkOutput("man_ch", 32'(out_ch), 32'd2);
      applyStimulus(1'b0, 2'd2, 2'd3, 4'b0101, 4'b1111, 1'b1);
      checkOutput("man_idle_ready", 32'(in_ready), 32'b0000);
      tick();
      checkOutput("man_idle_valid", 32'(out_valid), 32'd0);
      in_data[2*DATA_W +: DATA_W] = 8'h12;

      // Backpressure: pointer sits at 2, so ch3 loads, then holds for three edges.
      applyStimulus(1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 1'b1);
      tick();
      checkOutput("bp_load_ch", 32'(out_ch), 32'd3);
      applyStimulus(1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 1'b0);
      checkOutput("bp_ready_zero", 32'(in_ready), 32'b0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("bp_hold_data", 32'(out_data), 32'h13);
         checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_hold_ready", 32'(in_ready), 32'b0000);
      end
      applyStimulus(1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 1'b1);
      checkOutput("bp_release_ready", 32'(in_ready), 32'b0001);
      tick();
      checkOutput("bp_release_ch", 32'(out_ch), 32'd0);
      checkOutput("bp_release_data", 32'(out_data), 32'h10);

      // Reset in the middle of a ch3 packet drops the lock and the held beat.
      applyStimulus(1'b0, 2'd0, 2'd0, 4'b1000, 4'b0000, 1'b1);
      checkOutput("mid_ready", 32'(in_ready), 32'b1000);
      tick();
      checkOutput("mid_ch", 32'(out_ch), 32'd3);
      applyStimulus(1'b1, 2'd0, 2'd0, 4'b1111, 4'b0000, 1'b1);
      checkOutput("mid_rst_ready", 32'(in_ready), 32'b0000);
      tick();
      checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 1'b1);
      checkOutput("post_rst_ready", 32'(in_ready), 32'b0001);
      tick();
      checkOutput("post_rst_ch", 32'(out_ch), 32'd0);
      checkOutput("post_rst_valid", 32'(out_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
